// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer
// Watches a thermometer-coded start-light bar, then measures how many clock
// cycles pass between lights-out and the driver's button press. Illegal light
// patterns and early presses are flagged instead of producing a result.
//
// Optional feature: define F1_REACTION_TIMEOUT_EN to end a measurement with a
// timeout flag once the counter reaches its maximum. Without it the counter
// saturates and the block waits for the button indefinitely.
module f1_reaction_timer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     lights_in,
    input  logic                 btn,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] react_time,
    output logic                 valid,
    output logic                 false_start,
    output logic                 seq_err,
    output logic                 timeout
);

    localparam int LVL_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]     ALL_ON  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        FULL,
        TIMING,
        DONE,
        FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   react_time_q, react_time_d;
    logic                   valid_q, valid_d;
    logic                   false_start_q, false_start_d;
    logic                   seq_err_q, seq_err_d;
    logic                   timeout_q, timeout_d;

    // Thermometer pattern with the lowest n lights lit.
    function automatic logic [WIDTH-1:0] therm(input logic [LVL_W:0] n);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (i < int'(n));
        end
        return t;
    endfunction

    // Next-state and next-output decision; clr overrides every transition.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        count_d       = count_q;
        react_time_d  = react_time_q;
        valid_d       = valid_q;
        false_start_d = false_start_q;
        seq_err_d     = seq_err_q;
        timeout_d     = timeout_q;

        if (clr) begin
            state_d       = IDLE;
            level_d       = '0;
            count_d       = '0;
            react_time_d  = '0;
            valid_d       = 1'b0;
            false_start_d = 1'b0;
            seq_err_d     = 1'b0;
            timeout_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lights_in == '0) begin
                        state_d = IDLE;
                    end else if (lights_in == therm((LVL_W+1)'(1))) begin
                        state_d = ARMING;
                        level_d = LVL_W'(1);
                    end else begin
                        state_d   = FAULT;
                        seq_err_d = 1'b1;
                    end
                end
                ARMING: begin
                    if (btn) begin
                        state_d       = FAULT;
                        false_start_d = 1'b1;
                    end else if (lights_in == ALL_ON) begin
                        state_d = FULL;
                        level_d = LVL_W'(WIDTH);
                    end else if (lights_in == therm({1'b0, level_q})) begin
                        state_d = ARMING;
                    end else if (lights_in == therm({1'b0, level_q} + (LVL_W+1)'(1))) begin
                        level_d = level_q + LVL_W'(1);
                    end else begin
                        state_d   = FAULT;
                        seq_err_d = 1'b1;
                    end
                end
                FULL: begin
                    if (btn) begin
                        state_d       = FAULT;
                        false_start_d = 1'b1;
                    end else if (lights_in == '0) begin
                        state_d = TIMING;
                        count_d = '0;
                    end else if (lights_in != ALL_ON) begin
                        state_d   = FAULT;
                        seq_err_d = 1'b1;
                    end
                end
                TIMING: begin
                    if (btn) begin
                        state_d      = DONE;
                        react_time_d = count_q;
                        valid_d      = 1'b1;
`ifdef F1_REACTION_TIMEOUT_EN
                    end else if (count_q == CNT_MAX) begin
                        state_d      = DONE;
                        react_time_d = CNT_MAX;
                        timeout_d    = 1'b1;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
`else
                    end else if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_WIDTH'(1);
                    end
`endif
                end
                DONE, FAULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            level_q       <= '0;
            count_q       <= '0;
            react_time_q  <= '0;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            count_q       <= count_d;
            react_time_q  <= react_time_d;
            valid_q       <= valid_d;
            false_start_q <= false_start_d;
            seq_err_q     <= seq_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign react_time  = react_time_q;
    assign valid       = valid_q;
    assign false_start = false_start_q;
    assign seq_err     = seq_err_q;
    assign timeout     = timeout_q;

endmodule
